// File: rtl/fp_operand_unpack_if.sv
// Operand/result bundle for the FP operand unpacker: valid/ready input side
// carrying packed IEEE-754 operands and valid/ready output side with unpacked fields.
interface fp_operand_unpack_if #(
    parameter int unsigned EXP_W   = 8,
    parameter int unsigned MAN_W   = 23,
    parameter int unsigned NUM_OPS = 2
);
    localparam int unsigned OP_W  = 1 + EXP_W + MAN_W;
    localparam int unsigned XW    = EXP_W + 2;
    localparam int unsigned SW    = MAN_W + 1;
    localparam int unsigned CLS_W = 6;

    logic                       in_valid;
    logic                       in_ready;
    logic [NUM_OPS*OP_W-1:0]    in_op;
    logic                       out_valid;
    logic                       out_ready;
    logic [NUM_OPS-1:0]         out_sign;
    logic [NUM_OPS*XW-1:0]      out_exp;
    logic [NUM_OPS*SW-1:0]      out_sig;
    logic [NUM_OPS-1:0]         out_hidden;
    logic [NUM_OPS*CLS_W-1:0]   out_class;

    modport master (
        output in_valid, in_op, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_sig, out_hidden, out_class
    );

    modport slave (
        input  in_valid, in_op, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_sig, out_hidden, out_class
    );
endinterface

// File: rtl/fp_operand_unpack.sv
// Splits NUM_OPS packed IEEE-754 operands into sign/exponent/significand, classifies
// them, and optionally pre-normalises subnormals with a multi-cycle left shifter.
module fp_operand_unpack #(
    parameter int unsigned EXP_W      = 8,
    parameter int unsigned MAN_W      = 23,
    parameter int unsigned NUM_OPS    = 2,
    parameter int unsigned NORM_SUB   = 1,
    parameter int unsigned SHIFT_STEP = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    fp_operand_unpack_if.slave bus
);
    localparam int unsigned OP_W  = 1 + EXP_W + MAN_W;
    localparam int unsigned XW    = EXP_W + 2;
    localparam int unsigned SW    = MAN_W + 1;
    localparam int unsigned CLS_W = 6;
    localparam int unsigned LZ_W  = $clog2(SW + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_NORM = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]               state_q, state_d;
    logic                     in_ready_q, out_valid_q;
    logic [NUM_OPS-1:0]       sign_q, sign_d;
    logic [NUM_OPS*XW-1:0]    exp_q, exp_d;
    logic [NUM_OPS*SW-1:0]    sig_q, sig_d;
    logic [NUM_OPS-1:0]       hid_q, hid_d;
    logic [NUM_OPS*CLS_W-1:0] cls_q, cls_d;

    logic                     any_sub;
    logic                     all_done;
    logic [EXP_W-1:0]         fld_e;
    logic [MAN_W-1:0]         fld_m;
    logic [LZ_W-1:0]          lz;
    logic [LZ_W-1:0]          k;

    // Leading-zero count of a significand; callers only pass non-zero values.
    function automatic logic [LZ_W-1:0] lzc(input logic [SW-1:0] v);
        logic found;
        lzc   = '0;
        found = 1'b0;
        for (int j = SW - 1; j >= 0; j--) begin
            if (!found) begin
                if (v[j]) found = 1'b1;
                else      lzc   = lzc + LZ_W'(1);
            end
        end
    endfunction

    // Next state plus capture/classify in IDLE and one shift step per op in NORM.
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        sig_d    = sig_q;
        hid_d    = hid_q;
        cls_d    = cls_q;
        any_sub  = 1'b0;
        all_done = 1'b1;
        fld_e    = '0;
        fld_m    = '0;
        lz       = '0;
        k        = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    for (int i = 0; i < NUM_OPS; i++) begin
                        fld_e     = bus.in_op[i*OP_W + MAN_W +: EXP_W];
                        fld_m     = bus.in_op[i*OP_W +: MAN_W];
                        sign_d[i] = bus.in_op[i*OP_W + OP_W - 1];
                        if (fld_e == '0) begin
                            hid_d[i] = 1'b0;
                            if (fld_m == '0) begin
                                exp_d[i*XW +: XW]       = '0;
                                sig_d[i*SW +: SW]       = '0;
                                cls_d[i*CLS_W +: CLS_W] = 6'b000001;
                            end else begin
                                exp_d[i*XW +: XW]       = XW'(1);
                                sig_d[i*SW +: SW]       = {1'b0, fld_m};
                                cls_d[i*CLS_W +: CLS_W] = 6'b000010;
                                any_sub                 = 1'b1;
                            end
                        end else begin
                            hid_d[i]          = 1'b1;
                            exp_d[i*XW +: XW] = XW'(fld_e);
                            sig_d[i*SW +: SW] = {1'b1, fld_m};
                            if (fld_e != '1)
                                cls_d[i*CLS_W +: CLS_W] = 6'b000100;
                            else if (fld_m == '0)
                                cls_d[i*CLS_W +: CLS_W] = 6'b001000;
                            else if (fld_m[MAN_W-1])
                                cls_d[i*CLS_W +: CLS_W] = 6'b010000;
                            else
                                cls_d[i*CLS_W +: CLS_W] = 6'b100000;
                        end
                    end
                    state_d = (NORM_SUB != 0 && any_sub) ? S_NORM : S_HOLD;
                end
            end
            S_NORM: begin
                for (int i = 0; i < NUM_OPS; i++) begin
                    if (cls_q[i*CLS_W + 1] && !sig_q[i*SW + SW - 1]) begin
                        lz = lzc(sig_q[i*SW +: SW]);
                        k  = (lz > LZ_W'(SHIFT_STEP)) ? LZ_W'(SHIFT_STEP) : lz;
                        sig_d[i*SW +: SW] = sig_q[i*SW +: SW] << k;
                        exp_d[i*XW +: XW] = exp_q[i*XW +: XW] - XW'(k);
                        if (lz > LZ_W'(SHIFT_STEP)) all_done = 1'b0;
                    end
                end
                state_d = all_done ? S_HOLD : S_NORM;
            end
            S_HOLD: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            sign_q      <= '0;
            exp_q       <= '0;
            sig_q       <= '0;
            hid_q       <= '0;
            cls_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == S_IDLE);
            out_valid_q <= (state_d == S_HOLD);
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            sig_q       <= sig_d;
            hid_q       <= hid_d;
            cls_q       <= cls_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_sign   = sign_q;
    assign bus.out_exp    = exp_q;
    assign bus.out_sig    = sig_q;
    assign bus.out_hidden = hid_q;
    assign bus.out_class  = cls_q;
endmodule

// File: tb/tb_fp_operand_unpack.sv
// Directed self-checking bench for fp_operand_unpack: one normalising instance
// and one pass-through instance, hand-computed expected values.
module tb_fp_operand_unpack;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int unsigned NOPS  = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    fp_operand_unpack_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .NUM_OPS(NOPS)) bus_a ();
    fp_operand_unpack_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .NUM_OPS(NOPS)) bus_n ();

    fp_operand_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W), .NUM_OPS(NOPS),
                        .NORM_SUB(1), .SHIFT_STEP(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );

    fp_operand_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W), .NUM_OPS(NOPS),
                        .NORM_SUB(0), .SHIFT_STEP(4)) dut_ns (
        .clk(clk), .rst_n(rst_n), .bus(bus_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand a bundle to the normalising instance and measure cycles to out_valid.
    task automatic send_a(input logic [31:0] op0, input logic [31:0] op1, output int lat);
        int w;
        w = 0;
        while (!bus_a.in_ready && w < 20) begin
            tick();
            w++;
        end
        check("in_ready_before_send", 64'(bus_a.in_ready), 64'd1);
        bus_a.in_op    = {op1, op0};
        bus_a.in_valid = 1'b1;
        tick();
        bus_a.in_valid = 1'b0;
        lat = 1;
        while (!bus_a.out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_a();
        bus_a.out_ready = 1'b1;
        tick();
        bus_a.out_ready = 1'b0;
    endtask

    task automatic check_op_a(input string tag, input int i, input logic sgn, input logic [9:0] e,
                              input logic [23:0] s, input logic h, input logic [5:0] c);
        check({tag, "_sign"},   64'(bus_a.out_sign[i]),        64'(sgn));
        check({tag, "_exp"},    64'(bus_a.out_exp[i*10 +: 10]), 64'(e));
        check({tag, "_sig"},    64'(bus_a.out_sig[i*24 +: 24]), 64'(s));
        check({tag, "_hidden"}, 64'(bus_a.out_hidden[i]),      64'(h));
        check({tag, "_class"},  64'(bus_a.out_class[i*6 +: 6]), 64'(c));
    endtask

    initial begin
        int lat;
        checks          = 0;
        failures        = 0;
        rst_n           = 1'b0;
        bus_a.in_valid  = 1'b0;
        bus_a.in_op     = '0;
        bus_a.out_ready = 1'b0;
        bus_n.in_valid  = 1'b0;
        bus_n.in_op     = '0;
        bus_n.out_ready = 1'b0;

        tick();
        tick();
        check("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
        check("rst_in_ready",  64'(bus_a.in_ready),  64'd0);
        check("rst_out_exp",   64'(bus_a.out_exp),   64'd0);
        check("rst_out_class", 64'(bus_a.out_class), 64'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", 64'(bus_a.in_ready), 64'd1);

        // 1.0 and -0
        send_a(32'h3F800000, 32'h80000000, lat);
        check("norm_zero_latency", 64'(lat), 64'd1);
        check_op_a("one", 0, 1'b0, 10'd127, 24'h800000, 1'b1, 6'b000100);
        check_op_a("negzero", 1, 1'b1, 10'd0, 24'h000000, 1'b0, 6'b000001);
        release_a();
        check("after_release_valid", 64'(bus_a.out_valid), 64'd0);
        check("after_release_ready", 64'(bus_a.in_ready),  64'd1);

        // Subnormals: lz=23 needs ceil(23/4)=6 shift cycles
        send_a(32'h00000001, 32'h00400000, lat);
        check("sub_latency", 64'(lat), 64'd7);
        check_op_a("sub_min", 0, 1'b0, 10'h3EA, 24'h800000, 1'b0, 6'b000010);
        check_op_a("sub_big", 1, 1'b0, 10'h000, 24'h800000, 1'b0, 6'b000010);
        release_a();

        // NaNs and infinity
        send_a(32'h7FC00000, 32'h7F800001, lat);
        check("nan_latency", 64'(lat), 64'd1);
        check_op_a("qnan", 0, 1'b0, 10'd255, 24'hC00000, 1'b1, 6'b010000);
        check_op_a("snan", 1, 1'b0, 10'd255, 24'h800001, 1'b1, 6'b100000);
        release_a();
        send_a(32'h7F800000, 32'hFF800000, lat);
        check_op_a("pinf", 0, 1'b0, 10'd255, 24'h800000, 1'b1, 6'b001000);
        check_op_a("ninf", 1, 1'b1, 10'd255, 24'h800000, 1'b1, 6'b001000);

        // Backpressure: hold 5 cycles with a competing bundle offered
        bus_a.in_op    = {32'h40400000, 32'h40000000};
        bus_a.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_out_valid", 64'(bus_a.out_valid), 64'd1);
            check("bp_in_ready",  64'(bus_a.in_ready),  64'd0);
            check("bp_exp_stable", 64'(bus_a.out_exp), 64'({10'd255, 10'd255}));
        end
        bus_a.out_ready = 1'b1;
        tick();
        bus_a.out_ready = 1'b0;
        check("bp_release_valid", 64'(bus_a.out_valid), 64'd0);
        check("bp_release_ready", 64'(bus_a.in_ready),  64'd1);
        tick();
        bus_a.in_valid = 1'b0;
        check("bp_next_valid", 64'(bus_a.out_valid), 64'd1);
        check_op_a("two", 0, 1'b0, 10'd128, 24'h800000, 1'b1, 6'b000100);
        check_op_a("three", 1, 1'b0, 10'd128, 24'hC00000, 1'b1, 6'b000100);
        release_a();

        // Asynchronous reset during the third NORM cycle
        bus_a.in_op    = {32'h00000000, 32'h00000001};
        bus_a.in_valid = 1'b1;
        tick();
        bus_a.in_valid = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus_a.out_valid), 64'd0);
        check("midrst_in_ready",  64'(bus_a.in_ready),  64'd0);
        check("midrst_out_sig",   64'(bus_a.out_sig),   64'd0);
        check("midrst_out_exp",   64'(bus_a.out_exp),   64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("midrst_recover_ready", 64'(bus_a.in_ready), 64'd1);
        send_a(32'h3F800000, 32'h80000000, lat);
        check("recover_latency", 64'(lat), 64'd1);
        check_op_a("recover_one", 0, 1'b0, 10'd127, 24'h800000, 1'b1, 6'b000100);
        release_a();

        // Pass-through instance: subnormal keeps exp=1, hidden=0
        bus_n.in_op    = {32'h00000000, 32'h00000001};
        bus_n.in_valid = 1'b1;
        tick();
        bus_n.in_valid = 1'b0;
        check("ns_latency_valid", 64'(bus_n.out_valid), 64'd1);
        check("ns_exp",    64'(bus_n.out_exp[9:0]),   64'd1);
        check("ns_sig",    64'(bus_n.out_sig[23:0]),  64'h000001);
        check("ns_class",  64'(bus_n.out_class[5:0]), 64'b000010);
        check("ns_hidden", 64'(bus_n.out_hidden[0]),  64'd0);
        check("ns_op1_class", 64'(bus_n.out_class[11:6]), 64'b000001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
